// File: rtl/paquete_ps2.sv
// ============================================================================
// Module : paquete_ps2
// Brief  : Shared scan codes, FSM encoding and default parameters for the
//          PS/2 keyboard receiver.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package paquete_ps2;

  localparam logic [7:0] COD_BRK = 8'hF0;
  localparam logic [7:0] COD_EXT = 8'hE0;

  localparam int FILTRO_BITS_DEF = 8;
  localparam int TIMEOUT_DEF     = 200000;

  typedef enum logic [1:0] {
    s_espera = 2'd0,
    s_datos  = 2'd1,
    s_fin    = 2'd2
  } estado_t;

endpackage

`default_nettype wire

// File: rtl/filtro_ps2c.sv
// ============================================================================
// Module : filtro_ps2c
// Brief  : ps2c synchronizer, glitch filter and falling-edge pulse.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module filtro_ps2c
  import paquete_ps2::*;
#(
  parameter int FILTRO_BITS = FILTRO_BITS_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic ps2c,
  output logic flanco
);

  logic [1:0]             r_sync;
  logic [FILTRO_BITS-1:0] r_hist;
  logic                   r_filt;
  logic [FILTRO_BITS-1:0] w_hist_sig;
  logic                   w_filt_sig;

  // The window holds the newest sample plus the previous FILTRO_BITS-1 ones.
  always_comb begin
    w_hist_sig = {r_hist[FILTRO_BITS-2:0], r_sync[1]};
    w_filt_sig = r_filt;
    if (&w_hist_sig) begin
      w_filt_sig = 1'b1;
    end else if (~|w_hist_sig) begin
      w_filt_sig = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync <= 2'b11;
      r_hist <= '1;
      r_filt <= 1'b1;
      flanco <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], ps2c};
      r_hist <= w_hist_sig;
      r_filt <= w_filt_sig;
      flanco <= r_filt & ~w_filt_sig;
    end
  end

endmodule

`default_nettype wire

// File: rtl/receptor_ps2_tecla.sv
// ============================================================================
// Module : receptor_ps2_tecla
// Brief  : PS/2 keyboard frame receiver delivering make codes only.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module receptor_ps2_tecla
  import paquete_ps2::*;
#(
  parameter int FILTRO_BITS = FILTRO_BITS_DEF,
  parameter int TIMEOUT     = TIMEOUT_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2c,
  input  logic       ps2d,
  output logic [7:0] d_tecla,
  output logic       tecla_lista,
  output logic       error_trama
);

  localparam int TW = $clog2(TIMEOUT + 1);

  logic [1:0]    r_sync_d;
  logic          w_flanco;
  logic          w_dato;
  estado_t       r_estado, w_estado_sig;
  logic [9:0]    r_shift, w_shift_sig;
  logic [3:0]    r_nbits, w_nbits_sig;
  logic [TW-1:0] r_timeout, w_timeout_sig;
  logic          r_brk, w_brk_sig;
  logic [7:0]    w_tecla_sig;
  logic          w_lista_sig;
  logic          w_error_sig;

  filtro_ps2c #(
    .FILTRO_BITS(FILTRO_BITS)
  ) u_filtro (
    .clk   (clk),
    .reset (reset),
    .ps2c  (ps2c),
    .flanco(w_flanco)
  );

  assign w_dato = r_sync_d[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync_d    <= 2'b11;
      r_estado    <= s_espera;
      r_shift     <= '0;
      r_nbits     <= '0;
      r_timeout   <= '0;
      r_brk       <= 1'b0;
      d_tecla     <= 8'h00;
      tecla_lista <= 1'b0;
      error_trama <= 1'b0;
    end else begin
      r_sync_d    <= {r_sync_d[0], ps2d};
      r_estado    <= w_estado_sig;
      r_shift     <= w_shift_sig;
      r_nbits     <= w_nbits_sig;
      r_timeout   <= w_timeout_sig;
      r_brk       <= w_brk_sig;
      d_tecla     <= w_tecla_sig;
      tecla_lista <= w_lista_sig;
      error_trama <= w_error_sig;
    end
  end

  always_comb begin
    w_estado_sig  = r_estado;
    w_shift_sig   = r_shift;
    w_nbits_sig   = r_nbits;
    w_timeout_sig = r_timeout;
    w_brk_sig     = r_brk;
    w_tecla_sig   = 8'h00;
    w_lista_sig   = 1'b0;
    w_error_sig   = 1'b0;

    case (r_estado)
      s_espera: begin
        w_timeout_sig = '0;
        if (w_flanco && !w_dato) begin
          w_estado_sig = s_datos;
          w_nbits_sig  = '0;
          w_shift_sig  = '0;
        end
      end

      // Bits arrive LSB first; after 10 shifts: [7:0] data, [8] parity, [9] stop.
      s_datos: begin
        if (w_flanco) begin
          w_shift_sig   = {w_dato, r_shift[9:1]};
          w_timeout_sig = '0;
          if (r_nbits == 4'd9) begin
            w_estado_sig = s_fin;
          end else begin
            w_nbits_sig = r_nbits + 4'd1;
          end
        end else if (r_timeout == TW'(TIMEOUT - 1)) begin
          w_estado_sig  = s_espera;
          w_timeout_sig = '0;
        end else begin
          w_timeout_sig = r_timeout + TW'(1);
        end
      end

      s_fin: begin
        w_estado_sig = s_espera;
        w_nbits_sig  = '0;
        if ((^r_shift[8:0]) && r_shift[9]) begin
          if (r_shift[7:0] == COD_BRK) begin
            w_brk_sig = 1'b1;
          end else if (r_shift[7:0] == COD_EXT) begin
            w_brk_sig = r_brk;
          end else if (r_brk) begin
            w_brk_sig = 1'b0;
          end else begin
            w_tecla_sig = r_shift[7:0];
            w_lista_sig = 1'b1;
          end
        end else begin
          w_error_sig = 1'b1;
        end
      end

      default: w_estado_sig = s_espera;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_receptor_ps2_tecla.sv
// ============================================================================
// Module : tb_receptor_ps2_tecla
// Brief  : Self-checking bench for receptor_ps2_tecla.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_receptor_ps2_tecla;

  localparam int FB   = 8;
  localparam int TO   = 600;
  localparam int HALF = 30;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2c = 1'b1;
  logic       ps2d = 1'b1;
  logic [7:0] d_tecla;
  logic       tecla_lista;
  logic       error_trama;

  int n_tests = 0;
  int n_fail  = 0;
  int n_viol  = 0;
  int obs_err = 0;
  logic [7:0] obs_codes[$];

  receptor_ps2_tecla #(
    .FILTRO_BITS(FB),
    .TIMEOUT    (TO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .ps2c       (ps2c),
    .ps2d       (ps2d),
    .d_tecla    (d_tecla),
    .tecla_lista(tecla_lista),
    .error_trama(error_trama)
  );

  always #5 clk = ~clk;

  // Collect every strobe; track properties that must hold on every cycle.
  always @(negedge clk) begin
    if (!reset) begin
      if (tecla_lista === 1'b1) obs_codes.push_back(d_tecla);
      if (error_trama === 1'b1) obs_err++;
      if (tecla_lista === 1'b1 && error_trama === 1'b1) n_viol++;
      if (tecla_lista !== 1'b1 && d_tecla !== 8'h00) n_viol++;
    end
  end

  function automatic logic odd_par(input logic [7:0] d);
    return ~^d;
  endfunction

  task automatic clear_obs();
    obs_codes.delete();
    obs_err = 0;
  endtask

  task automatic ps2_bit(input logic b, input bit glitch);
    ps2d = b;
    if (glitch) begin
      repeat (10) @(negedge clk);
      ps2c = 1'b0;
      repeat (3) @(negedge clk);
      ps2c = 1'b1;
      repeat (HALF - 13) @(negedge clk);
    end else begin
      repeat (HALF) @(negedge clk);
    end
    ps2c = 1'b0;
    repeat (HALF) @(negedge clk);
    ps2c = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] data, input logic par, input logic stop,
                            input bit glitch);
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(data[i], glitch && (i == 3));
    ps2_bit(par, 1'b0);
    ps2_bit(stop, 1'b0);
    ps2d = 1'b1;
    repeat (60) @(negedge clk);
  endtask

  task automatic send_ok(input logic [7:0] data);
    send_frame(data, odd_par(data), 1'b1, 1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (5) @(negedge clk);
    n_tests++;
    if (d_tecla !== 8'h00) begin n_fail++; $display("FAIL reset_d_tecla got=%h exp=00", d_tecla); end
    n_tests++;
    if (tecla_lista !== 1'b0) begin n_fail++; $display("FAIL reset_lista got=%b exp=0", tecla_lista); end
    n_tests++;
    if (error_trama !== 1'b0) begin n_fail++; $display("FAIL reset_error got=%b exp=0", error_trama); end
    reset = 1'b0;
    clear_obs();
    repeat (40) @(negedge clk);
    n_tests++;
    if (obs_codes.size() != 0 || obs_err != 0) begin
      n_fail++; $display("FAIL idle_after_reset strobes=%0d errs=%0d exp=0/0", obs_codes.size(), obs_err);
    end
  endtask

  task automatic test_make();
    clear_obs();
    send_frame(8'h70, 1'b0, 1'b1, 1'b0);
    n_tests++;
    if (obs_codes.size() != 1) begin
      n_fail++; $display("FAIL make_count got=%0d exp=1", obs_codes.size());
    end else begin
      n_tests++;
      if (obs_codes[0] !== 8'h70) begin n_fail++; $display("FAIL make_code got=%h exp=70", obs_codes[0]); end
    end
    n_tests++;
    if (obs_err != 0) begin n_fail++; $display("FAIL make_err got=%0d exp=0", obs_err); end
    n_tests++;
    if (d_tecla !== 8'h00) begin n_fail++; $display("FAIL make_after got=%h exp=00", d_tecla); end
  endtask

  task automatic test_break();
    clear_obs();
    send_ok(8'hF0);
    send_ok(8'h70);
    n_tests++;
    if (obs_codes.size() != 0 || obs_err != 0) begin
      n_fail++; $display("FAIL break_release strobes=%0d errs=%0d exp=0/0", obs_codes.size(), obs_err);
    end
    send_ok(8'h73);
    n_tests++;
    if (obs_codes.size() != 1) begin
      n_fail++; $display("FAIL break_next_count got=%0d exp=1", obs_codes.size());
    end else begin
      n_tests++;
      if (obs_codes[0] !== 8'h73) begin n_fail++; $display("FAIL break_next_code got=%h exp=73", obs_codes[0]); end
    end
  endtask

  task automatic test_parity_error();
    clear_obs();
    send_frame(8'h72, 1'b0, 1'b1, 1'b0);
    n_tests++;
    if (obs_err != 1) begin n_fail++; $display("FAIL parity_err got=%0d exp=1", obs_err); end
    n_tests++;
    if (obs_codes.size() != 0) begin n_fail++; $display("FAIL parity_strobe got=%0d exp=0", obs_codes.size()); end
  endtask

  task automatic test_extended();
    clear_obs();
    send_ok(8'hE0);
    send_ok(8'h7A);
    // E0 between break and code must not clear the break flag.
    send_ok(8'hF0);
    send_ok(8'hE0);
    send_ok(8'h7A);
    n_tests++;
    if (obs_codes.size() != 1) begin
      n_fail++; $display("FAIL ext_count got=%0d exp=1", obs_codes.size());
    end else begin
      n_tests++;
      if (obs_codes[0] !== 8'h7A) begin n_fail++; $display("FAIL ext_code got=%h exp=7a", obs_codes[0]); end
    end
  endtask

  task automatic test_timeout();
    clear_obs();
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) ps2_bit(1'($urandom_range(0, 1)), 1'b0);
    ps2d = 1'b1;
    repeat (TO + 10) @(negedge clk);
    send_frame(8'h21, 1'b1, 1'b1, 1'b0);
    n_tests++;
    if (obs_codes.size() != 1 || obs_err != 0) begin
      n_fail++; $display("FAIL timeout_count strobes=%0d errs=%0d exp=1/0", obs_codes.size(), obs_err);
    end else begin
      n_tests++;
      if (obs_codes[0] !== 8'h21) begin n_fail++; $display("FAIL timeout_code got=%h exp=21", obs_codes[0]); end
    end
  endtask

  task automatic test_reset_mid_frame();
    clear_obs();
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) ps2_bit(1'b1, 1'b0);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    n_tests++;
    if (d_tecla !== 8'h00 || tecla_lista !== 1'b0 || error_trama !== 1'b0) begin
      n_fail++; $display("FAIL midreset_outs got=%h/%b/%b exp=00/0/0", d_tecla, tecla_lista, error_trama);
    end
    reset = 1'b0;
    ps2d  = 1'b1;
    repeat (20) @(negedge clk);
    clear_obs();
    send_frame(8'h2D, 1'b1, 1'b1, 1'b1);
    n_tests++;
    if (obs_codes.size() != 1 || obs_err != 0) begin
      n_fail++; $display("FAIL midreset_count strobes=%0d errs=%0d exp=1/0", obs_codes.size(), obs_err);
    end else begin
      n_tests++;
      if (obs_codes[0] !== 8'h2D) begin n_fail++; $display("FAIL midreset_code got=%h exp=2d", obs_codes[0]); end
    end
  endtask

  task automatic test_back_to_back();
    clear_obs();
    for (int i = 0; i < 3; i++) send_ok(8'h1C);
    n_tests++;
    if (obs_codes.size() != 3) begin
      n_fail++; $display("FAIL typematic_count got=%0d exp=3", obs_codes.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_tests++;
        if (obs_codes[i] !== 8'h1C) begin n_fail++; $display("FAIL typematic_code[%0d] got=%h exp=1c", i, obs_codes[i]); end
      end
    end
  endtask

  // Reference model: frame validity and make/break rules applied per frame.
  task automatic test_random();
    logic [7:0] exp_codes[$];
    int         exp_err = 0;
    bit         brk = 1'b0;
    logic [7:0] code, prev;
    logic       par, stop;
    int         sel;
    prev = 8'h15;
    clear_obs();
    for (int n = 0; n < 25; n++) begin
      sel = $urandom_range(0, 9);
      code = (sel == 0) ? 8'hF0 : (sel == 1) ? 8'hE0 : (sel == 2) ? prev : 8'($urandom_range(0, 255));
      par  = odd_par(code);
      if ($urandom_range(0, 5) == 0) par = ~par;
      stop = ($urandom_range(0, 9) != 0);
      send_frame(code, par, stop, 1'b0);
      if ((((^code) ^ par) != 1'b1) || !stop) exp_err++;
      else if (code == 8'hF0) brk = 1'b1;
      else if (code == 8'hE0) brk = brk;
      else if (brk) brk = 1'b0;
      else begin exp_codes.push_back(code); prev = code; end
    end
    n_tests++;
    if (obs_err != exp_err) begin n_fail++; $display("FAIL rand_errs got=%0d exp=%0d", obs_err, exp_err); end
    n_tests++;
    if (obs_codes.size() != exp_codes.size()) begin
      n_fail++; $display("FAIL rand_count got=%0d exp=%0d", obs_codes.size(), exp_codes.size());
    end else begin
      for (int i = 0; i < exp_codes.size(); i++) begin
        n_tests++;
        if (obs_codes[i] !== exp_codes[i]) begin
          n_fail++; $display("FAIL rand_code[%0d] got=%h exp=%h", i, obs_codes[i], exp_codes[i]);
        end
      end
    end
  endtask

  task automatic test_invariants();
    n_tests++;
    if (n_viol != 0) begin
      n_fail++; $display("FAIL invariants violations=%0d exp=0", n_viol);
    end
  endtask

  initial begin
    test_reset();
    test_make();
    test_break();
    test_parity_error();
    test_extended();
    test_timeout();
    test_reset_mid_frame();
    test_back_to_back();
    test_random();
    test_invariants();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/receptor_ps2_tecla.md
RECEPTOR_PS2_TECLA -- requirements
Module: receptor_ps2_tecla

Interface
REQ-001 SHALL have parameter FILTRO_BITS, default 8, number of consecutive equal samples needed to accept a ps2c level.
REQ-002 SHALL have parameter TIMEOUT, default 200000, clk cycles without a ps2c falling edge that abort a partial frame (2 ms at 100 MHz).
REQ-003 SHALL use one clock and an asynchronous, active-high reset: clk  in  1  system clock, 100 MHz.
REQ-004 SHALL provide reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL provide ps2c  in  1  raw PS/2 clock from the keyboard, asynchronous.
REQ-006 SHALL provide ps2d  in  1  raw PS/2 data from the keyboard, asynchronous.
REQ-007 SHALL provide d_tecla  out  8  make scan code, valid only while tecla_lista=1, otherwise 0x00.
REQ-008 SHALL provide tecla_lista  out  1  one-cycle strobe for a new make code.
REQ-009 SHALL provide error_trama  out  1  one-cycle strobe for a rejected frame (parity or stop-bit error).

Function
REQ-010 SHALL pass ps2c and ps2d each through a 2-FF synchronizer before any other use.
REQ-011 SHALL filter synchronized ps2c: filtered level becomes 1 after FILTRO_BITS consecutive 1 samples, 0 after FILTRO_BITS consecutive 0 samples, otherwise holds.
REQ-012 SHALL generate a one-cycle pulse (flanco) when filtered ps2c goes 1->0; ps2d is sampled in that same cycle.
REQ-013 SHALL implement FSM states s_espera, s_datos, s_fin; reset state s_espera.
REQ-014 s_espera: on flanco with ps2d=0 (start bit) -> s_datos, bit counter=0; flanco with ps2d=1 ignored.
REQ-015 s_datos: each flanco shifts ps2d in; order 8 data bits LSB first, parity, stop; after the 10th bit -> s_fin.
REQ-016 s_datos: timeout counter clears on each flanco; at TIMEOUT-1 without flanco -> s_espera, partial frame discarded, no strobe, break flag unchanged.
REQ-017 s_fin: frame valid iff odd parity over 8 data + parity bit AND stop bit=1; always -> s_espera after one cycle.
REQ-018 Invalid frame: error_trama=1 for one cycle, code discarded, break flag unchanged.
REQ-019 Valid code 0xF0: set break flag, no strobe.
REQ-020 Valid code 0xE0: no strobe, break flag unchanged (extended prefix ignored).
REQ-021 Valid other code with break flag set: clear break flag, no strobe (release suppressed).
REQ-022 Valid other code with break flag clear: d_tecla=code, tecla_lista=1 for exactly one cycle.
REQ-023 Latency: with stop-bit flanco in cycle E, s_fin is cycle E+1, strobes are visible in cycle E+2 (registered outputs).
REQ-024 Typematic repeats (same make code repeated) SHALL each produce a strobe.
REQ-025 tecla_lista and error_trama SHALL never be 1 in the same cycle.

Reset
REQ-026 reset SHALL force d_tecla=0x00, tecla_lista=0, error_trama=0, state=s_espera, break flag=0, counters=0, shift register=0, filtered ps2c=1, synchronizers=1.
REQ-027 reset mid-frame SHALL discard the partial frame; the next complete frame after reset deassertion decodes normally.

Structure
REQ-028 Package paquete_ps2 SHALL hold codes COD_BRK=0xF0, COD_EXT=0xE0, state encodings, and FILTRO_BITS/TIMEOUT defaults.
REQ-029 Sub-module filtro_ps2c SHALL contain ps2c synchronizer, glitch filter and falling-edge pulse; the FSM, ps2d synchronizer and break logic stay in receptor_ps2_tecla.

Verification
REQ-030 Frame 0x70, parity 0, stop 1 -> d_tecla=0x70, tecla_lista=1 for one cycle at E+2, then 0x00.
REQ-031 Frames 0xF0 then 0x70 -> no tecla_lista, no error_trama; following frame 0x73 -> d_tecla=0x73 strobe.
REQ-032 Frame 0x72 with parity 0 (wrong) -> error_trama one cycle, tecla_lista stays 0, d_tecla stays 0x00.
REQ-033 Frames 0xE0 then 0x7A -> single strobe with d_tecla=0x7A.
REQ-034 Start bit + 5 data bits, then ps2c idle for TIMEOUT+10 cycles -> no strobe; next frame 0x21 (parity 1) -> d_tecla=0x21 strobe.
REQ-035 Reset asserted after 4 bits of a frame -> all outputs 0x00/0; next frame 0x2D (parity 1) -> d_tecla=0x2D strobe; 3-cycle ps2c glitch mid-frame produces no extra bit.
